// File: rtl/ucsbece154b_scoreboard_pkg.sv
// ---------------------------------------------------------------------------
// ucsbece154b_scoreboard_pkg
// Shared constants for the dual-issue register scoreboard: register-index
// width, number of architectural registers, pending-counter width and the
// index of the hard-wired zero register.
// ---------------------------------------------------------------------------
package ucsbece154b_scoreboard_pkg;

  localparam int SB_REG_W = 5;
  localparam int SB_NREG  = 32;
  localparam int SB_CNT_W = 2;

  localparam logic [SB_REG_W-1:0] SB_X0 = 5'd0;

endpackage

// File: rtl/ucsbece154b_sb_counter.sv
// ---------------------------------------------------------------------------
// ucsbece154b_sb_counter
// Pending-write counter for one architectural register.
//   clk, reset   : clock, asynchronous active-high reset
//   inc          : number of issued writes to this register this cycle (0..2)
//   dec          : number of writebacks to this register this cycle (0..2)
//   count        : current pending-write count
//   nonzero      : count != 0
//   saturated    : count is at its maximum value
//   error        : this cycle's update underflowed or overflowed
// ---------------------------------------------------------------------------
module ucsbece154b_sb_counter
  import ucsbece154b_scoreboard_pkg::*;
#(
  parameter int CNT_W = SB_CNT_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [1:0]       inc,
  input  logic [1:0]       dec,
  output logic [CNT_W-1:0] count,
  output logic             nonzero,
  output logic             saturated,
  output logic             error
);

  // Two extra bits hold count + 2 without wrapping.
  localparam int SUM_W = CNT_W + 2;
  localparam logic [SUM_W-1:0] MAX_V = {2'b00, {CNT_W{1'b1}}};

  logic [CNT_W-1:0] count_r;
  logic [CNT_W-1:0] count_next_s;
  logic [SUM_W-1:0] sum_s;
  logic [SUM_W-1:0] dec_ext_s;
  logic [SUM_W-1:0] diff_s;
  logic             err_s;

  // Next-count computation with clamping at both ends.
  always_comb begin
    sum_s        = {2'b00, count_r} + {{CNT_W{1'b0}}, inc};
    dec_ext_s    = {{CNT_W{1'b0}}, dec};
    diff_s       = sum_s - dec_ext_s;
    count_next_s = count_r;
    err_s        = 1'b0;
    if (dec_ext_s > sum_s) begin
      // More retirements than pending writes: clamp to empty.
      count_next_s = {CNT_W{1'b0}};
      err_s        = 1'b1;
    end else if (diff_s > MAX_V) begin
      count_next_s = {CNT_W{1'b1}};
      err_s        = 1'b1;
    end else begin
      count_next_s = diff_s[CNT_W-1:0];
      err_s        = 1'b0;
    end
  end

  // Counter state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_r <= {CNT_W{1'b0}};
    end else begin
      count_r <= count_next_s;
    end
  end

  assign count     = count_r;
  assign nonzero   = (count_r != {CNT_W{1'b0}});
  assign saturated = (count_r == {CNT_W{1'b1}});
  assign error     = err_s;

endmodule

// File: rtl/ucsbece154b_scoreboard.sv
// ---------------------------------------------------------------------------
// ucsbece154b_scoreboard
// Dual-issue register scoreboard between decode and the dual-ported register
// file. Grants issue per slot when all used sources have no pending writes
// and the destination counter has room, resolves RAW/WAW within the pair, and
// retires pending writes from the two writeback ports.
//   clk, reset                       : clock, asynchronous active-high reset
//   valid_iN, rs1/rs2/rd_iN, uses_*  : slot N instruction from decode
//   flush_i                          : squash this cycle's issue
//   we_iN, a3_iN                     : writeback port N (register file write)
//   issue_o1, issue_o2               : combinational per-slot grant
//   busy_o                           : per-register pending-write indication
//   err_o                            : sticky counter underflow/overflow flag
// ---------------------------------------------------------------------------
module ucsbece154b_scoreboard
  import ucsbece154b_scoreboard_pkg::*;
#(
  parameter int NREG  = SB_NREG,
  parameter int CNT_W = SB_CNT_W
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                valid_i1,
  input  logic [SB_REG_W-1:0] rs1_i1,
  input  logic [SB_REG_W-1:0] rs2_i1,
  input  logic [SB_REG_W-1:0] rd_i1,
  input  logic                uses_rs1_i1,
  input  logic                uses_rs2_i1,
  input  logic                writes_rd_i1,
  input  logic                valid_i2,
  input  logic [SB_REG_W-1:0] rs1_i2,
  input  logic [SB_REG_W-1:0] rs2_i2,
  input  logic [SB_REG_W-1:0] rd_i2,
  input  logic                uses_rs1_i2,
  input  logic                uses_rs2_i2,
  input  logic                writes_rd_i2,
  input  logic                flush_i,
  input  logic                we_i1,
  input  logic [SB_REG_W-1:0] a3_i1,
  input  logic                we_i2,
  input  logic [SB_REG_W-1:0] a3_i2,
  output logic                issue_o1,
  output logic                issue_o2,
  output logic [NREG-1:0]     busy_o,
  output logic                err_o
);

  logic [CNT_W-1:0] count_s [NREG];
  logic [NREG-1:0]  nonzero_s;
  logic [NREG-1:0]  sat_s;
  logic [NREG-1:0]  cnt_err_s;

  logic issue1_s;
  logic issue2_s;
  logic rdy11_s, rdy12_s, full1_s;
  logic rdy21_s, rdy22_s, full2_s;
  logic raw_s, waw_s;
  logic err_r;

  // x0 is never tracked.
  assign count_s[0]   = {CNT_W{1'b0}};
  assign nonzero_s[0] = 1'b0;
  assign sat_s[0]     = 1'b0;
  assign cnt_err_s[0] = 1'b0;

  for (genvar r = 1; r < NREG; r++) begin : g_cnt
    logic [1:0] inc_s;
    logic [1:0] dec_s;

    assign inc_s = {1'b0, issue1_s & writes_rd_i1 & (rd_i1 == SB_REG_W'(r))}
                 + {1'b0, issue2_s & writes_rd_i2 & (rd_i2 == SB_REG_W'(r))};
    assign dec_s = {1'b0, we_i1 & (a3_i1 == SB_REG_W'(r))}
                 + {1'b0, we_i2 & (a3_i2 == SB_REG_W'(r))};

    ucsbece154b_sb_counter #(
      .CNT_W (CNT_W)
    ) u_cnt (
      .clk       (clk),
      .reset     (reset),
      .inc       (inc_s),
      .dec       (dec_s),
      .count     (count_s[r]),
      .nonzero   (nonzero_s[r]),
      .saturated (sat_s[r]),
      .error     (cnt_err_s[r])
    );
  end

  // Readiness, destination room and in-order pair grant.
  always_comb begin
    // Sources read the register file directly, so only a zero count is ready.
    rdy11_s = !uses_rs1_i1 || (rs1_i1 == SB_X0) || (count_s[rs1_i1] == {CNT_W{1'b0}});
    rdy12_s = !uses_rs2_i1 || (rs2_i1 == SB_X0) || (count_s[rs2_i1] == {CNT_W{1'b0}});
    full1_s = writes_rd_i1 && (rd_i1 != SB_X0) && sat_s[rd_i1];
    issue1_s = valid_i1 && !flush_i && rdy11_s && rdy12_s && !full1_s;

    rdy21_s = !uses_rs1_i2 || (rs1_i2 == SB_X0) || (count_s[rs1_i2] == {CNT_W{1'b0}});
    rdy22_s = !uses_rs2_i2 || (rs2_i2 == SB_X0) || (count_s[rs2_i2] == {CNT_W{1'b0}});

    raw_s = writes_rd_i1 && (rd_i1 != SB_X0) &&
            ((uses_rs1_i2 && (rs1_i2 == rd_i1)) || (uses_rs2_i2 && (rs2_i2 == rd_i1)));
    waw_s = writes_rd_i1 && writes_rd_i2 && (rd_i1 == rd_i2) && (rd_i2 != SB_X0);

    if (!writes_rd_i2 || (rd_i2 == SB_X0)) begin
      full2_s = 1'b0;
    end else if (waw_s) begin
      // Both slots land on the same counter: it needs room for two.
      full2_s = (({1'b0, count_s[rd_i2]} + {{(CNT_W-1){1'b0}}, 2'd2}) >
                 {1'b0, {CNT_W{1'b1}}});
    end else begin
      full2_s = sat_s[rd_i2];
    end

    issue2_s = issue1_s && valid_i2 && rdy21_s && rdy22_s && !full2_s && !raw_s;
  end

  // Sticky error flag.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      err_r <= 1'b0;
    end else begin
      err_r <= err_r | (|cnt_err_s);
    end
  end

  assign issue_o1 = issue1_s;
  assign issue_o2 = issue2_s;
  assign busy_o   = nonzero_s;
  assign err_o    = err_r;

endmodule
